cpu_decode: RTL and testbench
=============================

// Module: cpu_decode
// PURPOSE
//  Moxie decode stage, directly upstream of the execute stage. Accepts 16-bit
//  instruction words from fetch, classifies the three moxie encoding forms and
//  gathers the 32-bit immediate carried by long-immediate ops (two extra
//  halfwords). Presents a registered op/operand/register-index bundle to
//  execute and the register-file read port; inserts bubbles via stall_o.
// PARAMETERS
//  BIG_ENDIAN_IMM  1  1: first immediate halfword is bits 31:16; 0: bits 15:0
// PORTS
//  clk_i                  in   1   clock, single domain
//  rst_i                  in   1   reset, asynchronous, active-low
//  fetch_valid_i          in   1   fetch_word_i holds a valid halfword
//  fetch_word_i           in   16  instruction or immediate halfword
//  fetch_ready_o          out  1   decode accepts a word this cycle (= !hold_i)
//  hold_i                 in   1   downstream freeze; all state and outputs hold
//  flush_i                in   1   discard any partial instruction (taken branch)
//  op_o                   out  6   internal opcode (`OP_* from defines.v)
//  regA_index_o           out  4   register-file read index A
//  regB_index_o           out  4   register-file read index B
//  register_write_index_o out  4   destination register index for execute
//  operand_o              out  32  immediate / offset operand
//  stall_o                out  1   1 = bundle invalid (bubble); drives execute stall_i
// BEHAVIOUR
//  Reset (rst_i=0, async): state=S_DECODE, op_o=`OP_NOP, stall_o=1,
//   regA/regB/register_write_index_o=0, operand_o=0, immediate buffer=0.
//  Word accepted when fetch_valid_i & fetch_ready_o & !flush_i.
//  FSM: S_DECODE -> S_IMM0 -> S_IMM1 -> S_DECODE.
//   S_DECODE, word accepted, form1 long-imm op: latch op/A/B, go S_IMM0, stall_o=1.
//   S_DECODE, word accepted, any other op: bundle valid next cycle (latency 1),
//    stall_o=0, stay S_DECODE.
//   S_IMM0 accept: store half 0, go S_IMM1, stall_o=1.
//   S_IMM1 accept: assemble operand_o, stall_o=0 next cycle, go S_DECODE.
//   No word accepted (and no hold): stall_o=1 next cycle, op_o=`OP_NOP.
//  Field rules (instr = fetch_word_i):
//   form1 [15]=0: opcode [13:8], A=[7:4], B=[3:0]; write index=A; operand=0
//    unless long-imm.
//   form2 [15:14]=10: sub-op [13:12] inc/dec/gsr/ssr, A=[11:8], write index=A,
//    operand_o = zero-extended [7:0].
//   form3 [15:14]=11: branch cond [13:10], operand_o = sign-extend([9:0])<<1,
//    indices 0.
//   Undefined encodings -> op_o=`OP_BAD, stall_o=0 (execute handles trap).
//  Long-imm membership comes from the shared table (ldi.l=0x01, lda.l, sta.l,
//   jmpa, jsra, ldo.l, sto.l, ...).
//  hold_i=1: every register keeps its value incl. stall_o; fetch_ready_o=0.
//  flush_i=1 (not held): FSM -> S_DECODE, partial immediate discarded,
//   stall_o=1 next cycle; flush beats a simultaneous fetch word.
//  hold_i and flush_i both 1: hold wins; flush must be re-presented.
//  Reset mid-immediate: FSM returns to S_DECODE; no partial bundle ever issues.
// STRUCTURE
//  defines.v: `OP_* codes, form encodings, long-imm opcode list.
//  Sub-module cpu_decode_table: combinational raw opcode -> {`OP_*, is_long_imm,
//   is_bad}.
//  cpu_decode: FSM, immediate buffer, output registers.
// TESTING
//  Reset released, no fetch -> stall_o=1, op_o=`OP_NOP, all indices 0.
//  Word 0x0120,0x1234,0x5678 (ldi.l $r2 eq) -> 2 bubbles, then op_o=`OP_LDI_L,
//   operand_o=0x12345678, write index=2, stall_o=0 for one cycle.
//  Form2 dec $r3,0x05 -> next cycle op_o=`OP_DEC, operand_o=0x00000005,
//   write index=3.
//  Branch offset 0x3FF -> operand_o=0xFFFFFFFE; hold_i high 3 cycles mid-stream
//   -> outputs frozen, fetch_ready_o=0.
//  flush_i after first ldi.l immediate half -> no LDI_L issued, following
//   xor decodes with operand_o=0.
//  Undefined form1 opcode -> op_o=`OP_BAD, stall_o=0; async reset in S_IMM1 ->
//   stall_o=1 immediately.

Source files
------------

// File: rtl/cpu_decode_pkg.sv
// cpu_decode_pkg: internal op codes, decode FSM states and the long-immediate opcode set.
package cpu_decode_pkg;
  typedef enum logic [1:0] {S_DECODE, S_IMM0, S_IMM1} state_t;
  localparam logic [5:0] OP_BAD   = 6'h00;
  localparam logic [5:0] OP_LDI_L = 6'h01;
  localparam logic [5:0] OP_NOP   = 6'h0F;
  localparam logic [5:0] OP_XOR   = 6'h2E;
  // Form2 and branch ops live in code points left free by the form1 map
  localparam logic [5:0] OP_INC   = 6'h16;
  localparam logic [5:0] OP_DEC   = 6'h17;
  localparam logic [5:0] OP_GSR   = 6'h18;
  localparam logic [5:0] OP_SSR   = 6'h35;
  localparam logic [5:0] OP_BEQ   = 6'h36;
  localparam logic [3:0] BR_COND_MAX = 4'd9;
  function automatic logic is_long_imm(input logic [5:0] op);
    return op inside {6'h01, 6'h03, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h1A, 6'h1B,
                      6'h1D, 6'h1F, 6'h20, 6'h22, 6'h24, 6'h30};
  endfunction
endpackage

// File: rtl/cpu_decode_table.sv
// cpu_decode_table: maps the instruction's upper byte to an internal op plus long-imm / undefined flags.
module cpu_decode_table
  import cpu_decode_pkg::*;
(
  input  logic [7:0] i_hi,
  output logic [5:0] o_op,
  output logic       o_long_imm,
  output logic       o_bad
);
  logic [6:0] w_raw;
  logic [3:0] w_cond;
  logic       w_f1_bad;
  assign w_raw    = i_hi[6:0];
  assign w_cond   = i_hi[5:2];
  // Form1 codes 0x16-0x18 and 0x35 upward are repurposed, so they decode as undefined
  assign w_f1_bad = w_raw[6] | (w_raw[5:0] == 6'h00) | (w_raw[5:0] inside {[6'h16:6'h18]}) |
                    (w_raw[5:0] > 6'h34);
  assign o_op = !i_hi[7] ? (w_f1_bad ? OP_BAD : w_raw[5:0]) :
                !i_hi[6] ? ((i_hi[5:4] == 2'd3) ? OP_SSR : OP_INC + {4'd0, i_hi[5:4]}) :
                (w_cond > BR_COND_MAX) ? OP_BAD : OP_BEQ + {2'd0, w_cond};
  assign o_long_imm = !i_hi[7] & !w_f1_bad & is_long_imm(w_raw[5:0]);
  assign o_bad = (o_op == OP_BAD);
endmodule

// File: rtl/cpu_decode.sv
// cpu_decode: moxie decode stage; gathers long immediates and registers the bundle for execute.
module cpu_decode
  import cpu_decode_pkg::*;
#(
  parameter bit BIG_ENDIAN_IMM = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_valid_i,
  input  logic [15:0] fetch_word_i,
  output logic        fetch_ready_o,
  input  logic        hold_i,
  input  logic        flush_i,
  output logic [5:0]  op_o,
  output logic [3:0]  regA_index_o,
  output logic [3:0]  regB_index_o,
  output logic [3:0]  register_write_index_o,
  output logic [31:0] operand_o,
  output logic        stall_o
);
  state_t      r_state, w_state_nx;
  logic [5:0]  r_op, r_p_op, w_op, w_op_nx;
  logic [3:0]  r_a, r_b, r_p_a, r_p_b, w_a, w_b, w_a_nx, w_b_nx;
  logic [31:0] r_operand, w_imm, w_operand_nx;
  logic [15:0] r_half;
  logic        r_stall, w_long, w_bad, w_accept, w_issue, w_form1, w_form2;
  cpu_decode_table u_table (
    .i_hi       (fetch_word_i[15:8]),
    .o_op       (w_op),
    .o_long_imm (w_long),
    .o_bad      (w_bad)
  );
  assign w_form1  = !fetch_word_i[15];
  assign w_form2  = fetch_word_i[15:14] == 2'b10;
  assign w_a      = w_form1 ? fetch_word_i[7:4] : w_form2 ? fetch_word_i[11:8] : 4'd0;
  assign w_b      = w_form1 ? fetch_word_i[3:0] : 4'd0;
  assign w_imm    = w_form1 ? 32'd0 : w_form2 ? {24'd0, fetch_word_i[7:0]} :
                    {{21{fetch_word_i[9]}}, fetch_word_i[9:0], 1'b0};
  assign w_accept = fetch_valid_i & !hold_i & !flush_i;
  assign fetch_ready_o = !hold_i;
  always_comb begin
    w_state_nx   = r_state;
    w_issue      = 1'b0;
    w_op_nx      = w_op;
    w_a_nx       = w_a;
    w_b_nx       = w_b;
    w_operand_nx = w_imm;
    if (flush_i) w_state_nx = S_DECODE;
    else if (w_accept && r_state == S_DECODE) begin
      w_state_nx = (w_long & !w_bad) ? S_IMM0 : S_DECODE;
      w_issue    = !(w_long & !w_bad);
    end else if (w_accept && r_state == S_IMM0) w_state_nx = S_IMM1;
    else if (w_accept) begin
      w_state_nx   = S_DECODE;
      w_issue      = 1'b1;
      w_op_nx      = r_p_op;
      w_a_nx       = r_p_a;
      w_b_nx       = r_p_b;
      w_operand_nx = BIG_ENDIAN_IMM ? {r_half, fetch_word_i} : {fetch_word_i, r_half};
    end
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_DECODE;
    else if (!hold_i) r_state <= w_state_nx;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall   <= 1'b1;
      r_op      <= OP_NOP;
      r_a       <= 4'd0;
      r_b       <= 4'd0;
      r_operand <= 32'd0;
      r_p_op    <= OP_NOP;
      r_p_a     <= 4'd0;
      r_p_b     <= 4'd0;
      r_half    <= 16'd0;
    end else if (!hold_i) begin
      r_stall <= !w_issue;
      r_op    <= w_issue ? w_op_nx : OP_NOP;
      if (w_issue) begin
        r_a       <= w_a_nx;
        r_b       <= w_b_nx;
        r_operand <= w_operand_nx;
      end
      if (w_accept && r_state == S_DECODE) begin
        r_p_op <= w_op;
        r_p_a  <= w_a;
        r_p_b  <= w_b;
      end
      r_half <= flush_i ? 16'd0 : (w_accept && r_state == S_IMM0) ? fetch_word_i : r_half;
    end
  end
  assign op_o                   = r_op;
  assign regA_index_o           = r_a;
  assign regB_index_o           = r_b;
  assign register_write_index_o = r_a;
  assign operand_o              = r_operand;
  assign stall_o                = r_stall;
endmodule

// File: tb/tb_cpu_decode.sv
// tb_cpu_decode: directed-vector bench for cpu_decode with hand-computed expectations.
module tb_cpu_decode;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        fetch_valid_i;
  logic [15:0] fetch_word_i;
  logic        fetch_ready_o;
  logic        hold_i;
  logic        flush_i;
  logic [5:0]  op_o;
  logic [3:0]  regA_index_o, regB_index_o, register_write_index_o;
  logic [31:0] operand_o;
  logic        stall_o;
  int n_chk = 0;
  int n_fail = 0;
  cpu_decode #(.BIG_ENDIAN_IMM(1'b1)) dut (
    .clk_i                  (clk_i),
    .rst_i                  (rst_i),
    .fetch_valid_i          (fetch_valid_i),
    .fetch_word_i           (fetch_word_i),
    .fetch_ready_o          (fetch_ready_o),
    .hold_i                 (hold_i),
    .flush_i                (flush_i),
    .op_o                   (op_o),
    .regA_index_o           (regA_index_o),
    .regB_index_o           (regB_index_o),
    .register_write_index_o (register_write_index_o),
    .operand_o              (operand_o),
    .stall_o                (stall_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic v, input logic [15:0] w);
    fetch_valid_i = v;
    fetch_word_i  = w;
    @(negedge clk_i);
  endtask
  initial begin
    rst_i = 1'b0;
    fetch_valid_i = 1'b0;
    fetch_word_i = 16'h0000;
    hold_i = 1'b0;
    flush_i = 1'b0;
    #12;
    chk("rst_stall", {31'd0, stall_o}, 32'd1);
    chk("rst_op", {26'd0, op_o}, 32'h0F);
    chk("rst_operand", operand_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    cyc(1'b0, 16'h0000);
    chk("idle_stall", {31'd0, stall_o}, 32'd1);
    chk("idle_op", {26'd0, op_o}, 32'h0F);
    chk("idle_idx", {20'd0, regA_index_o, regB_index_o, register_write_index_o}, 32'd0);
    chk("idle_ready", {31'd0, fetch_ready_o}, 32'd1);
    // ldi.l $r2, 0x12345678
    cyc(1'b1, 16'h0120);
    chk("ldi_bub0_stall", {31'd0, stall_o}, 32'd1);
    chk("ldi_bub0_op", {26'd0, op_o}, 32'h0F);
    cyc(1'b1, 16'h1234);
    chk("ldi_bub1_stall", {31'd0, stall_o}, 32'd1);
    cyc(1'b1, 16'h5678);
    chk("ldi_op", {26'd0, op_o}, 32'h01);
    chk("ldi_operand", operand_o, 32'h12345678);
    chk("ldi_wr", {28'd0, register_write_index_o}, 32'd2);
    chk("ldi_stall", {31'd0, stall_o}, 32'd0);
    cyc(1'b0, 16'h0000);
    chk("ldi_after_stall", {31'd0, stall_o}, 32'd1);
    chk("ldi_after_op", {26'd0, op_o}, 32'h0F);
    // dec $r3, 0x05
    cyc(1'b1, 16'h9305);
    chk("dec_op", {26'd0, op_o}, 32'h17);
    chk("dec_operand", operand_o, 32'h00000005);
    chk("dec_wr", {28'd0, register_write_index_o}, 32'd3);
    chk("dec_stall", {31'd0, stall_o}, 32'd0);
    // beq with offset 0x3FF
    cyc(1'b1, 16'hC3FF);
    chk("br_op", {26'd0, op_o}, 32'h36);
    chk("br_operand", operand_o, 32'hFFFFFFFE);
    chk("br_idx", {20'd0, regA_index_o, regB_index_o, register_write_index_o}, 32'd0);
    hold_i = 1'b1;
    fetch_valid_i = 1'b1;
    fetch_word_i = 16'h9305;
    #1;
    chk("hold_ready", {31'd0, fetch_ready_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("hold_op", {26'd0, op_o}, 32'h36);
      chk("hold_operand", operand_o, 32'hFFFFFFFE);
      chk("hold_stall", {31'd0, stall_o}, 32'd0);
    end
    hold_i = 1'b0;
    cyc(1'b0, 16'h0000);
    chk("unhold_stall", {31'd0, stall_o}, 32'd1);
    // flush after first immediate half, then xor $r1,$r2
    cyc(1'b1, 16'h0120);
    cyc(1'b1, 16'h1234);
    flush_i = 1'b1;
    cyc(1'b1, 16'h5678);
    chk("flush_stall", {31'd0, stall_o}, 32'd1);
    chk("flush_op", {26'd0, op_o}, 32'h0F);
    flush_i = 1'b0;
    cyc(1'b1, 16'h2E12);
    chk("xor_op", {26'd0, op_o}, 32'h2E);
    chk("xor_operand", operand_o, 32'd0);
    chk("xor_ab", {24'd0, regA_index_o, regB_index_o}, 32'h12);
    chk("xor_stall", {31'd0, stall_o}, 32'd0);
    // undefined encodings
    cyc(1'b1, 16'h1600);
    chk("bad_f1_op", {26'd0, op_o}, 32'h00);
    chk("bad_f1_stall", {31'd0, stall_o}, 32'd0);
    cyc(1'b1, 16'hFC00);
    chk("bad_br_op", {26'd0, op_o}, 32'h00);
    // async reset while waiting for the second immediate half
    cyc(1'b1, 16'h0120);
    cyc(1'b1, 16'h1234);
    fetch_valid_i = 1'b0;
    #2 rst_i = 1'b0;
    #1;
    chk("arst_stall", {31'd0, stall_o}, 32'd1);
    chk("arst_op", {26'd0, op_o}, 32'h0F);
    chk("arst_operand", operand_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    cyc(1'b1, 16'h5678);
    chk("arst_next_op", {26'd0, op_o}, 32'h00);
    chk("arst_next_stall", {31'd0, stall_o}, 32'd0);
    chk("arst_next_a", {28'd0, regA_index_o}, 32'd7);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
